key_sched_ctrl: RTL and testbench
=================================

# key_sched_ctrl

Sequencer for the AES-128 key schedule. On a start handshake it iterates the single-round key-expansion datapath (`key_exp`) ten times, one round per clock, and stores all eleven round keys in an internal register file. The cipher round controller then reads the round keys by index through a registered read port. The block sits between the key-load interface and the encrypt datapath.

## Interface
Parameters:
- `NR`, default 10: number of AES rounds; fixed at 10 for AES-128. Other values are unsupported.
- `KW`, default 128: key and round-key width in bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request expansion of `key_in`; sampled only when `ready`=1.
- `key_in`, input, [0:127]: cipher key, byte 0 at bits [0:7].
- `ready`, output, 1: high in IDLE and DONE; the block can accept `start`.
- `busy`, output, 1: high while in EXPAND.
- `done`, output, 1: one-cycle pulse when `rk[NR]` has been written.
- `keys_valid`, output, 1: all round keys are valid; stays high until the next accepted `start` or `clear`.
- `clear`, input, 1: synchronous zeroize of all round keys and return to IDLE; has priority over `start`.
- `rk_addr`, input, 4: round-key index, 0..10.
- `rk_data`, output, [0:127]: registered round key for the `rk_addr` sampled on the previous edge.

## Operation
States: IDLE, EXPAND, DONE.
- IDLE → EXPAND on `start` && !`clear`. On that edge: `rk[0]`<=`key_in`, `work`<=`key_in`, `rnd`<=1, `keys_valid`<=0.
- In EXPAND, on each edge: `rk[rnd]`<=`key_exp(work, rnd)`, `work`<= the same value, `rnd`<=`rnd`+1.
  - On the edge where `rnd`==`NR`: go to DONE, `done`<=1 for one cycle, `keys_valid`<=1.
- DONE → EXPAND on `start` (a new key; the old keys are overwritten). DONE otherwise holds.
- `start` is ignored while in EXPAND; `ready`=0 there.
- `clear` in any state, on the next edge: all `rk[i]`<=0, `work`<=0, `rnd`<=0, `keys_valid`<=0, `done`<=0, state IDLE.
  - `clear` during EXPAND aborts the expansion and does not produce a `done` pulse.
- `rnd` is 4 bits and never exceeds 10. `rnd` drives the `round_number` input of `key_exp` directly, so the round constant for round r is applied at index r.
- Read port: `rk_data`<=`rk[rk_addr]` on every edge.
  - If `rk_addr`>10, `rk_data`<=0.
  - A read during EXPAND returns the current register contents, which may be stale. Consumers must qualify reads with `keys_valid`.
  - A read of an index on the same edge it is written returns the old value; there is no write-through.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `keys_valid`=0, `rk_data`=0, all `rk[i]`=0, `rnd`=0.
- Latency: with `start` accepted at edge E0, `rk[1..10]` are written at edges E1..E10. `done` and `keys_valid` are high in the cycle after E10, i.e. 11 cycles from start.
- Throughput: one expansion per 11 cycles. A `start` held high in DONE restarts immediately.
- Read latency: 1 cycle.
- Critical path: one `key_exp` evaluation (S-box plus XOR chain) from `work` to `rk`. Nothing else is chained combinationally.
- Asynchronous reset mid-EXPAND returns every output to its reset value at once.

## Structure
- Shared package `aes_pkg`:
  - constants `AES_NR`=10, `AES_KW`=128;
  - the state enum `ks_state_t` (IDLE, EXPAND, DONE);
  - the round-key index type (4 bits).
- Exactly one sub-module: a `key_exp` instance. Its input is `work`, its round number is `rnd`, and its output feeds `rk[rnd]` and `work`.
- The register file is 11×128 flops in-module; no RAM macro.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, pulse `start` → `done` exactly 11 cycles later; `rk[1]`=`a0fafe1788542cb123a339392a6c7605`; `rk[10]`=`d014f9a8c9ee2589e13f0cc8b6630ca6`; `rk[0]`=key.
- Read sweep of `rk_addr` 0..15 after `done` → each `rk_data` appears one cycle later; indices 11..15 return 0.
- `start` pulsed again during EXPAND with a different key → ignored; results match the first key; exactly one `done`.
- `clear` asserted at the 5th EXPAND cycle → state IDLE, no `done`, `keys_valid`=0, every read returns 0.
- `rst_n` dropped mid-EXPAND, then a fresh start with the all-zero key → `rk[1]`=`62636363626363636263636362636363`, `rk[10]`=`b4ef5bcb3e92e21123e951cf6f8f188e`.
- Back-to-back: `start` held high in DONE with key B → `keys_valid` falls on the next edge; the B round keys are correct 11 cycles later.

Source files
------------

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 key-schedule definitions: round count and key width,
// the sequencer state type, the round-key index type, and the byte-level
// helpers (S-box lookup, round constant) used by the key-expansion round.
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_KW = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  typedef logic [3:0] rk_idx_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  // Round constant for round r (1..10); index 0 and out-of-range give 0.
  function automatic logic [7:0] rcon(input rk_idx_t r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// ----------------------------------------------------------------------------
// key_sched_ctrl_if
// Bundle between the key loader / round controller (master) and the
// key-schedule sequencer (slave).
//   start, key_in, clear, rk_addr : master -> slave
//   ready, busy, done, keys_valid, rk_data : slave -> master
// Keys are byte-0-first: byte 0 occupies bits [0:7].
// ----------------------------------------------------------------------------
interface key_sched_ctrl_if #(
  parameter int KW = 128
);
  import aes_pkg::*;

  logic          start;
  logic [0:KW-1] key_in;
  logic          clear;
  rk_idx_t       rk_addr;
  logic          ready;
  logic          busy;
  logic          done;
  logic          keys_valid;
  logic [0:KW-1] rk_data;

  modport master (
    output start, key_in, clear, rk_addr,
    input  ready, busy, done, keys_valid, rk_data
  );

  modport slave (
    input  start, key_in, clear, rk_addr,
    output ready, busy, done, keys_valid, rk_data
  );

endinterface

// File: rtl/key_sched_ctrl_key_exp.sv
// ----------------------------------------------------------------------------
// key_exp
// One AES-128 key-expansion round, purely combinational.
//   key_cur      : round key r-1 (word 0 in the top 32 bits)
//   round_number : r, selects the round constant
//   key_nxt      : round key r
// ----------------------------------------------------------------------------
module key_exp
  import aes_pkg::*;
(
  input  logic [127:0] key_cur,
  input  rk_idx_t      round_number,
  output logic [127:0] key_nxt
);

  logic [31:0] w3_s;
  logic [31:0] rot_s;
  logic [31:0] temp_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  assign w3_s   = key_cur[31:0];
  assign rot_s  = {w3_s[23:0], w3_s[31:24]};
  assign temp_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
                   sbox(rot_s[15:8]),  sbox(rot_s[7:0])}
                  ^ {rcon(round_number), 24'h000000};

  // Each new word chains off the previous new word, so this XOR ladder
  // plus the S-box is the deepest combinational path in the block.
  assign n0_s = key_cur[127:96] ^ temp_s;
  assign n1_s = key_cur[95:64]  ^ n0_s;
  assign n2_s = key_cur[63:32]  ^ n1_s;
  assign n3_s = w3_s            ^ n2_s;

  assign key_nxt = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// key_sched_ctrl
// AES-128 key-schedule sequencer. A start in IDLE/DONE loads key_in as
// round key 0, then one key_exp round per clock fills round keys 1..NR.
// The round controller reads keys through a one-cycle registered port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_sched_ctrl_if slave (start/key_in/clear/rk_addr in;
//                ready/busy/done/keys_valid/rk_data out)
// ----------------------------------------------------------------------------
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input logic             clk,
  input logic             rst_n,
  key_sched_ctrl_if.slave bus
);

  localparam rk_idx_t LAST_RND = rk_idx_t'(NR);

  ks_state_t     state_r, state_nxt_s;
  logic          ready_r, busy_r, done_r, keys_valid_r;
  rk_idx_t       rnd_r;
  logic [KW-1:0] work_r;
  logic [KW-1:0] rk_r [0:NR];
  logic [KW-1:0] rk_data_r, rd_mux_s, kexp_s;
  logic          load_s, step_s, last_s;

  key_exp u_key_exp (
    .key_cur      (work_r),
    .round_number (rnd_r),
    .key_nxt      (kexp_s)
  );

  // State register; ready/busy are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != EXPAND);
      busy_r  <= (state_nxt_s == EXPAND);
    end
  end

  // Next-state logic; clear dominates everything.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = bus.start ? EXPAND : IDLE;
        EXPAND:  state_nxt_s = (rnd_r == LAST_RND) ? DONE : EXPAND;
        DONE:    state_nxt_s = bus.start ? EXPAND : DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    last_s = 1'b0;
    if (bus.clear) begin
      load_s = 1'b0;
      step_s = 1'b0;
      last_s = 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: load_s = bus.start;
        EXPAND: begin
          step_s = 1'b1;
          last_s = (rnd_r == LAST_RND);
        end
        default: begin
          load_s = 1'b0;
          step_s = 1'b0;
          last_s = 1'b0;
        end
      endcase
    end
  end

  // Round-key file, working key, round counter and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) rk_r[i] <= '0;
      work_r       <= '0;
      rnd_r        <= 4'd0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else if (bus.clear) begin
      for (int i = 0; i <= NR; i++) rk_r[i] <= '0;
      work_r       <= '0;
      rnd_r        <= 4'd0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else begin
      done_r <= last_s;
      if (load_s) begin
        rk_r[0]      <= bus.key_in;
        work_r       <= bus.key_in;
        rnd_r        <= 4'd1;
        keys_valid_r <= 1'b0;
      end else if (step_s) begin
        for (int i = 1; i <= NR; i++) begin
          if (rnd_r == rk_idx_t'(i)) rk_r[i] <= kexp_s;
        end
        work_r       <= kexp_s;
        // Park the counter at 0 after the last round so it never passes NR.
        rnd_r        <= last_s ? 4'd0 : rnd_r + 4'd1;
        keys_valid_r <= last_s;
      end
    end
  end

  // Read mux; indices above NR fall through to zero.
  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i <= NR; i++) begin
      rd_mux_s = (bus.rk_addr == rk_idx_t'(i)) ? rk_r[i] : rd_mux_s;
    end
  end

  // Registered read port; samples the file before this edge's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_r <= '0;
    end else begin
      rk_data_r <= rd_mux_s;
    end
  end

  assign bus.ready      = ready_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.keys_valid = keys_valid_r;
  assign bus.rk_data    = rk_data_r;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_sched_ctrl
// Self-checking bench for key_sched_ctrl. Expected round keys come from a
// word-recursive AES-128 expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map, and from FIPS-197 golden constants.
// ----------------------------------------------------------------------------
module tb_key_sched_ctrl;

  logic clk;
  logic rst_n;

  key_sched_ctrl_if bus ();

  key_sched_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb     [0:255];
  logic [127:0] ref_rk [0:10];
  logic [127:0] old_rk [0:10];

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t vecs [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-by-word AES-128 key expansion into ref_rk.
  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic read_rk(input int idx, output logic [127:0] d);
    bus.rk_addr = 4'(idx);
    tick();
    d = bus.rk_data;
  endtask

  task automatic sweep(input string tag, input bit zero);
    logic [127:0] d, want;
    for (int a = 0; a < 16; a++) begin
      read_rk(a, d);
      want = (a <= 10 && !zero) ? ref_rk[a] : 128'h0;
      chk($sformatf("%s_rd%0d", tag, a), d, want);
    end
  endtask

  // Pulse start with key; returns cycles from the accepting edge to done.
  task automatic run_expand(input logic [127:0] key, output int lat);
    bus.key_in = key;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    lat = 1;
    chk("busy_in_expand", 128'(bus.busy), 128'h1);
    chk("ready_in_expand", 128'(bus.ready), 128'h0);
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat, nd;
    logic [127:0] d, key_a, key_b;

    build_sbox();
    vecs[0].name = "fips";
    vecs[0].key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].rk1  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[0].rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[1].name = "zero";
    vecs[1].key  = 128'h0;
    vecs[1].rk1  = 128'h62636363626363636263636362636363;
    vecs[1].rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.clear   = 1'b0;
    bus.key_in  = '0;
    bus.rk_addr = 4'd0;
    repeat (3) tick();
    chk("rst_ready", 128'(bus.ready), 128'h1);
    chk("rst_busy", 128'(bus.busy), 128'h0);
    chk("rst_done", 128'(bus.done), 128'h0);
    chk("rst_keys_valid", 128'(bus.keys_valid), 128'h0);
    chk("rst_rk_data", bus.rk_data, 128'h0);
    rst_n = 1'b1;
    tick();
    sweep("rst", 1'b1);

    // Golden vectors
    for (int v = 0; v < 2; v++) begin
      ref_expand(vecs[v].key);
      run_expand(vecs[v].key, lat);
      chk({vecs[v].name, "_latency"}, 128'(lat), 128'd11);
      chk({vecs[v].name, "_keys_valid"}, 128'(bus.keys_valid), 128'h1);
      chk({vecs[v].name, "_ready"}, 128'(bus.ready), 128'h1);
      tick();
      chk({vecs[v].name, "_done_pulse"}, 128'(bus.done), 128'h0);
      read_rk(0, d);  chk({vecs[v].name, "_rk0"}, d, vecs[v].key);
      read_rk(1, d);  chk({vecs[v].name, "_rk1"}, d, vecs[v].rk1);
      read_rk(10, d); chk({vecs[v].name, "_rk10"}, d, vecs[v].rk10);
      sweep(vecs[v].name, 1'b0);
    end

    // start during EXPAND is ignored
    key_a = {$urandom, $urandom, $urandom, $urandom};
    ref_expand(key_a);
    bus.key_in = key_a; bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (3) tick();
    bus.key_in = ~key_a; bus.start = 1'b1; tick(); bus.start = 1'b0;
    count_done(20, nd);
    chk("ignore_start_done_count", 128'(nd), 128'd1);
    sweep("ignore_start", 1'b0);

    // clear in the 5th EXPAND cycle
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (4) tick();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    chk("clear_ready", 128'(bus.ready), 128'h1);
    chk("clear_busy", 128'(bus.busy), 128'h0);
    chk("clear_keys_valid", 128'(bus.keys_valid), 128'h0);
    count_done(15, nd);
    chk("clear_no_done", 128'(nd), 128'd0);
    sweep("clear", 1'b1);
    bus.start = 1'b1; bus.clear = 1'b1; tick();
    bus.start = 1'b0; bus.clear = 1'b0;
    chk("clear_over_start_busy", 128'(bus.busy), 128'h0);
    chk("clear_over_start_ready", 128'(bus.ready), 128'h1);

    // async reset mid-EXPAND, then zero key
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 128'(bus.ready), 128'h1);
    chk("arst_busy", 128'(bus.busy), 128'h0);
    chk("arst_done", 128'(bus.done), 128'h0);
    chk("arst_keys_valid", 128'(bus.keys_valid), 128'h0);
    chk("arst_rk_data", bus.rk_data, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    ref_expand(128'h0);
    run_expand(128'h0, lat);
    chk("arst_zero_latency", 128'(lat), 128'd11);
    tick();
    read_rk(1, d);  chk("arst_zero_rk1", d, vecs[1].rk1);
    read_rk(10, d); chk("arst_zero_rk10", d, vecs[1].rk10);

    // start held high in DONE: immediate restart, no write-through on rk0
    for (int r = 0; r <= 10; r++) old_rk[r] = ref_rk[r];
    key_b = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    ref_expand(key_b);
    bus.rk_addr = 4'd0; bus.key_in = key_b; bus.start = 1'b1;
    tick();
    chk("b2b_keys_valid_fall", 128'(bus.keys_valid), 128'h0);
    chk("b2b_no_write_through", bus.rk_data, old_rk[0]);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    bus.start = 1'b0;
    chk("b2b_latency", 128'(lat), 128'd11);
    sweep("b2b", 1'b0);

    // randomized keys and reads against the model
    for (int n = 0; n < 20; n++) begin
      key_a = {$urandom, $urandom, $urandom, $urandom};
      ref_expand(key_a);
      run_expand(key_a, lat);
      chk($sformatf("rand%0d_latency", n), 128'(lat), 128'd11);
      for (int k = 0; k < 6; k++) begin
        int a;
        a = int'($urandom_range(0, 15));
        read_rk(a, d);
        chk($sformatf("rand%0d_rd%0d", n, a), d, (a <= 10) ? ref_rk[a] : 128'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
